// File: rtl/lwm_pkg.sv
// lwm_pkg: shared state type and helpers for the level_width_meter block.
// Optional feature macro used by the block: LWM_TIMESTAMP_EN.
package lwm_pkg;

  // Measurement FSM: waiting for a rise, or counting a high interval
  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  // Largest value a counter of the given width can hold
  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/lwm_fifo.sv
// lwm_fifo: single-clock result FIFO for level_width_meter.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
// The head output reads 0 while the FIFO is empty.
module lwm_fifo
  import lwm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : mem[rptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the head is masked while empty
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/level_width_meter.sv
// level_width_meter: measures each high interval of a synchronous level in clk cycles,
// emits registered rise/fall pulses and queues finished widths in a small FIFO.
// Optional macro LWM_TIMESTAMP_EN adds a free-running timestamp captured at each rise
// and presented on width_ts alongside the queued width.
module level_width_meter
  import lwm_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DEPTH = 4,
  parameter int MIN_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             level,
  input  logic             meas_en,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] width_data,
  output logic             width_sat,
  output logic             width_valid,
  input  logic             width_ready,
  output logic             drop_sticky
`ifdef LWM_TIMESTAMP_EN
  ,
  output logic [CNT_W-1:0] width_ts
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_W);

  typedef struct packed {
    logic [CNT_W-1:0] width;
    logic             sat;
`ifdef LWM_TIMESTAMP_EN
    logic [CNT_W-1:0] ts;
`endif
  } entry_t;

  state_t           state;
  state_t           state_next;
  logic             level_q;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             sat;
  logic             sat_next;
  logic             push_req;
  logic             pop;
  logic             full;
  logic             empty;
  entry_t           push_entry;
  entry_t           head_entry;

  assign rise        = level && !level_q;
  assign fall        = !level && level_q;
  assign busy        = (state == MEAS);
  assign width_valid = !empty;
  assign pop         = width_valid && width_ready;
  assign width_data  = head_entry.width;
  assign width_sat   = head_entry.sat;

`ifdef LWM_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_cnt;
  logic [CNT_W-1:0] ts_cap;

  // Free-running timestamp, latched at the rise that starts an accepted measurement
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt <= '0;
      ts_cap <= '0;
    end else begin
      ts_cnt <= ts_cnt + CNT_W'(1);
      if (state == IDLE && rise && meas_en) ts_cap <= ts_cnt;
    end
  end

  assign width_ts = head_entry.ts;
`endif

  // Pack the finished measurement into a FIFO entry
  always_comb begin
    push_entry       = '0;
    push_entry.width = cnt;
    push_entry.sat   = sat;
`ifdef LWM_TIMESTAMP_EN
    push_entry.ts    = ts_cap;
`endif
  end

  // Level history, registered edge pulses, FSM state, counter and sticky drop flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q     <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      sat         <= 1'b0;
      drop_sticky <= 1'b0;
    end else begin
      level_q    <= level;
      rise_pulse <= rise;
      fall_pulse <= fall;
      state      <= state_next;
      cnt        <= cnt_next;
      sat        <= sat_next;
      if (push_req && full && !pop) drop_sticky <= 1'b1;
    end
  end

  // Next-state logic: start on an enabled rise, count while high, finish or abort
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sat_next   = sat;
    push_req   = 1'b0;
    case (state)
      IDLE: begin
        if (rise && meas_en) begin
          state_next = MEAS;
          cnt_next   = CNT_W'(1);
          sat_next   = 1'b0;
        end
      end
      MEAS: begin
        if (!meas_en) begin
          state_next = IDLE;
          cnt_next   = '0;
          sat_next   = 1'b0;
        end else if (level) begin
          if (cnt == CNT_MAX) sat_next = 1'b1;
          else                cnt_next = cnt + CNT_W'(1);
        end else begin
          state_next = IDLE;
          push_req   = (cnt >= MIN_V);
          cnt_next   = '0;
          sat_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        sat_next   = 1'b0;
      end
    endcase
  end

  lwm_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (full),
    .empty (empty)
  );

endmodule
